// File: rtl/multicycle_main_control.sv
// Multi-cycle main control: Moore FSM sequencing FETCH/DECODE/EXEC/MEM/WB with a mem_ready handshake.
// Optional feature macro: ILLEGAL_OP_TRAP_EN (unsupported opcodes park the FSM in TRAP until reset).
module multicycle_main_control #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int STATE_W  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic [1:0]          pc_source,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                illegal_op,
    output logic [STATE_W-1:0]  state_o
);

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = STATE_W'(0),
        ST_FETCH    = STATE_W'(1),
        ST_DECODE   = STATE_W'(2),
        ST_MEM_ADDR = STATE_W'(3),
        ST_MEM_RD   = STATE_W'(4),
        ST_WB_LW    = STATE_W'(5),
        ST_MEM_WR   = STATE_W'(6),
        ST_EXEC_R   = STATE_W'(7),
        ST_WB_R     = STATE_W'(8),
        ST_EXEC_I   = STATE_W'(9),
        ST_WB_I     = STATE_W'(10),
        ST_BRANCH   = STATE_W'(11),
`ifdef ILLEGAL_OP_TRAP_EN
        ST_JUMP     = STATE_W'(12),
        ST_TRAP     = STATE_W'(13)
`else
        ST_JUMP     = STATE_W'(12)
`endif
    } state_t;

    typedef struct packed {
        logic               pc_write;
        logic               pc_write_cond;
        logic [1:0]         pc_source;
        logic               i_or_d;
        logic               mem_read;
        logic               mem_write;
        logic               ir_write;
        logic               reg_dst;
        logic               mem_to_reg;
        logic               reg_write;
        logic               alu_src_a;
        logic [1:0]         alu_src_b;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(35);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(43);

    state_t state;
    state_t next_state;
    ctrl_t  ctrl;

    // Control word for a state; outputs are registered from the next state so they stay Moore.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.pc_write  = 1'b1;
            end
            ST_DECODE:   c.alu_src_b = 2'b11;
            ST_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            ST_MEM_RD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            ST_WB_LW: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            ST_MEM_WR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            ST_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALUOP_W'(2'b10);
            end
            ST_WB_R: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            ST_EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            ST_WB_I:     c.reg_write = 1'b1;
            ST_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALUOP_W'(2'b01);
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            ST_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            default:     c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        next_state = ST_FETCH;
        case (state)
            ST_IDLE:     next_state = ST_FETCH;
            ST_FETCH:    next_state = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (opcode == OP_R)                          next_state = ST_EXEC_R;
                else if (opcode == OP_LW || opcode == OP_SW) next_state = ST_MEM_ADDR;
                else if (opcode == OP_BEQ)                   next_state = ST_BRANCH;
                else if (opcode == OP_ADDI)                  next_state = ST_EXEC_I;
                else if (opcode == OP_J)                     next_state = ST_JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
                else                                         next_state = ST_TRAP;
`else
                else                                         next_state = ST_FETCH;
`endif
            end
            ST_MEM_ADDR: begin
                if (opcode == OP_SW)      next_state = ST_MEM_WR;
                else if (opcode == OP_LW) next_state = ST_MEM_RD;
                else                      next_state = ST_FETCH;
            end
            ST_MEM_RD:   next_state = mem_ready ? ST_WB_LW : ST_MEM_RD;
            ST_MEM_WR:   next_state = mem_ready ? ST_FETCH : ST_MEM_WR;
            ST_EXEC_R:   next_state = ST_WB_R;
            ST_EXEC_I:   next_state = ST_WB_I;
`ifdef ILLEGAL_OP_TRAP_EN
            ST_TRAP:     next_state = ST_TRAP;
`endif
            default:     next_state = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            ctrl  <= '0;
        end else begin
            state <= next_state;
            ctrl  <= decode_ctrl(next_state);
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) illegal_q <= 1'b0;
        else          illegal_q <= (next_state == ST_TRAP);
    end
    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign pc_source     = ctrl.pc_source;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign state_o       = state;

endmodule
